// File: rtl/decode_sequencer_pkg.sv
// Shared types and constants for the npc decode sequencer.
package decode_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_DECODE  = 3'd1,
      ST_ISSUE   = 3'd2,
      ST_WAIT_WB = 3'd3,
      ST_HALT    = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      INST_R   = 3'd0,
      INST_I   = 3'd1,
      INST_S   = 3'd2,
      INST_B   = 3'd3,
      INST_U   = 3'd4,
      INST_J   = 3'd5,
      INST_ILL = 3'd7
   } inst_type_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [31:0] EBREAK_ENC = 32'h0010_0073;

   localparam logic [1:0] FAULT_NONE     = 2'd0;
   localparam logic [1:0] FAULT_ILLEGAL  = 2'd1;
   localparam logic [1:0] FAULT_TIMEOUT  = 2'd2;
   localparam logic [1:0] FAULT_MISALIGN = 2'd3;

endpackage

// File: rtl/decode_sequencer_inst_type_decode.sv
// Opcode to instruction-class decode for the immediate extender.
module inst_type_decode
   import decode_sequencer_pkg::*;
(
   input  logic [6:0] opcode,
   output inst_type_e inst_type,
   output logic       illegal
);

   // Map the major opcode to its class; anything unlisted is illegal.
   always_comb begin
      inst_type = INST_ILL;
      illegal   = 1'b0;
      case (opcode)
         OPC_OP:                                     inst_type = INST_R;
         OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: inst_type = INST_I;
         OPC_STORE:                                  inst_type = INST_S;
         OPC_BRANCH:                                 inst_type = INST_B;
         OPC_LUI, OPC_AUIPC:                         inst_type = INST_U;
         OPC_JAL:                                    inst_type = INST_J;
         default:                                    illegal   = 1'b1;
      endcase
   end

endmodule

// File: rtl/decode_sequencer.sv
// Multi-cycle fetch/decode/issue/writeback sequencer owning PC and IR.
module decode_sequencer
   import decode_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] EBREAK   = EBREAK_ENC
) (
   input  logic        clk,
   input  logic        rst,
   output logic        inst_req_o,
   output logic [31:0] inst_addr_o,
   input  logic        inst_valid_i,
   input  logic [31:0] inst_i,
   output logic [4:0]  rs2_o,
   output logic [6:0]  funct7_o,
   output inst_type_e  type_o,
   input  logic [31:0] imm32_i,
   output logic        ex_valid_o,
   input  logic        ex_ready_i,
   output logic [31:0] ex_imm_o,
   output logic [31:0] ex_inst_o,
   output logic [31:0] pc_o,
   input  logic        wb_done_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        halt_o,
   output logic [1:0]  fault_o,
   output logic [31:0] retire_cnt_o
);

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] imm_q, imm_d;
   logic        halt_q, halt_d;
   logic [1:0]  fault_q, fault_d;
   logic [31:0] retire_q, retire_d;
   logic [15:0] tcnt_q, tcnt_d;

   inst_type_e  dec_type;
   logic        dec_illegal;

   inst_type_decode u_type_dec (
      .opcode    (ir_q[6:0]),
      .inst_type (dec_type),
      .illegal   (dec_illegal)
   );

   // Cleared IR reports R-type so the extender produces zero out of reset.
   assign type_o       = (ir_q == '0) ? INST_R : dec_type;
   assign rs2_o        = ir_q[24:20];
   assign funct7_o     = ir_q[31:25];
   assign inst_req_o   = (state_q == ST_FETCH) && !rst;
   assign inst_addr_o  = pc_q;
   assign ex_valid_o   = (state_q == ST_ISSUE);
   assign ex_imm_o     = imm_q;
   assign ex_inst_o    = ir_q;
   assign pc_o         = pc_q;
   assign halt_o       = halt_q;
   assign fault_o      = fault_q;
   assign retire_cnt_o = retire_q;

   // State register and datapath registers; everything frozen in HALT by the next-state logic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_FETCH;
         pc_q     <= RESET_PC;
         ir_q     <= '0;
         imm_q    <= '0;
         halt_q   <= 1'b0;
         fault_q  <= FAULT_NONE;
         retire_q <= '0;
         tcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         imm_q    <= imm_d;
         halt_q   <= halt_d;
         fault_q  <= fault_d;
         retire_q <= retire_d;
         tcnt_q   <= tcnt_d;
      end
   end

   // Next-state and datapath updates for each sequencing step.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      imm_d    = imm_q;
      halt_d   = halt_q;
      fault_d  = fault_q;
      retire_d = retire_q;
      tcnt_d   = tcnt_q;
      case (state_q)
         ST_FETCH: begin
            if (inst_valid_i) begin
               ir_d    = inst_i;
               tcnt_d  = '0;
               state_d = ST_DECODE;
            end else if (tcnt_q == TO_LAST) begin
               fault_d = FAULT_TIMEOUT;
               halt_d  = 1'b1;
               state_d = ST_HALT;
            end else begin
               tcnt_d = tcnt_q + 16'd1;
            end
         end
         ST_DECODE: begin
            imm_d = imm32_i;
            if (ir_q == EBREAK) begin
               halt_d  = 1'b1;
               fault_d = FAULT_NONE;
               state_d = ST_HALT;
            end else if (dec_illegal) begin
               halt_d  = 1'b1;
               fault_d = FAULT_ILLEGAL;
               state_d = ST_HALT;
            end else begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (ex_ready_i) state_d = ST_WAIT_WB;
         end
         ST_WAIT_WB: begin
            if (wb_done_i) begin
               retire_d = retire_q + 32'd1;
               if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) begin
                  halt_d  = 1'b1;
                  fault_d = FAULT_MISALIGN;
                  state_d = ST_HALT;
               end else begin
                  pc_d    = redirect_i ? redirect_pc_i : pc_q + 32'd4;
                  state_d = ST_FETCH;
               end
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_HALT;
         end
      endcase
   end

endmodule

// File: tb/tb_decode_sequencer.sv
// Self-checking bench for decode_sequencer with a packet scoreboard.
module tb_decode_sequencer;
   import decode_sequencer_pkg::*;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] imm;
      logic [31:0] pc;
   } pkt_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inst_req_o;
   logic [31:0] inst_addr_o;
   logic        inst_valid_i = 1'b0;
   logic [31:0] inst_i = '0;
   logic [4:0]  rs2_o;
   logic [6:0]  funct7_o;
   inst_type_e  type_o;
   logic [31:0] imm32_i;
   logic        ex_valid_o;
   logic        ex_ready_i = 1'b0;
   logic [31:0] ex_imm_o;
   logic [31:0] ex_inst_o;
   logic [31:0] pc_o;
   logic        wb_done_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        halt_o;
   logic [1:0]  fault_o;
   logic [31:0] retire_cnt_o;

   int   errors = 0;
   int   checks = 0;
   pkt_t sb[$];

   always #5 clk = ~clk;

   // Minimal extender: I-type sign-extends {funct7,rs2}, everything else yields zero.
   assign imm32_i = (type_o == INST_I) ? {{20{funct7_o[6]}}, funct7_o, rs2_o} : 32'd0;

   decode_sequencer #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o),
      .inst_valid_i(inst_valid_i), .inst_i(inst_i),
      .rs2_o(rs2_o), .funct7_o(funct7_o), .type_o(type_o), .imm32_i(imm32_i),
      .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
      .ex_imm_o(ex_imm_o), .ex_inst_o(ex_inst_o), .pc_o(pc_o),
      .wb_done_i(wb_done_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .halt_o(halt_o), .fault_o(fault_o), .retire_cnt_o(retire_cnt_o)
   );

   // Scoreboard: on each accepted handshake compare the packet against the expected one.
   always begin
      pkt_t e;
      @(negedge clk);
      #1;
      if (ex_valid_o === 1'b1 && ex_ready_i === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: accepted inst %h with nothing expected", ex_inst_o);
         end else begin
            e = sb.pop_front();
            if ({ex_inst_o, ex_imm_o, pc_o} !== e) begin
               errors++;
               $display("FAIL sb_packet: got inst=%h imm=%h pc=%h expected inst=%h imm=%h pc=%h",
                        ex_inst_o, ex_imm_o, pc_o, e.inst, e.imm, e.pc);
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      inst_valid_i = 1'b0; ex_ready_i = 1'b0; wb_done_i = 1'b0; redirect_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({inst_req_o, ex_valid_o, halt_o, fault_o} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got req=%b valid=%b halt=%b fault=%0d expected all 0",
                  inst_req_o, ex_valid_o, halt_o, fault_o);
      end
      checks++;
      if (pc_o !== 32'h8000_0000 || retire_cnt_o !== 32'd0 || ex_inst_o !== 32'd0 || ex_imm_o !== 32'd0) begin
         errors++;
         $display("FAIL reset_data: got pc=%h retire=%0d ir=%h imm=%h expected 80000000/0/0/0",
                  pc_o, retire_cnt_o, ex_inst_o, ex_imm_o);
      end
      checks++;
      if (type_o !== INST_R) begin
         errors++;
         $display("FAIL reset_type: got %0d expected %0d", type_o, INST_R);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h8000_0000) begin
         errors++;
         $display("FAIL reset_first_fetch: got req=%b addr=%h expected 1/80000000", inst_req_o, inst_addr_o);
      end
   endtask

   task automatic test_addi();
      inst_valid_i = 1'b1; inst_i = 32'hFFF0_0093; ex_ready_i = 1'b1;
      sb.push_back('{inst: 32'hFFF0_0093, imm: 32'hFFFF_FFFF, pc: 32'h8000_0000});
      @(negedge clk);
      inst_valid_i = 1'b0;
      checks++;
      if (type_o !== INST_I || ex_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL addi_decode: got type=%0d valid=%b expected %0d/0", type_o, ex_valid_o, INST_I);
      end
      @(negedge clk);
      checks++;
      if (ex_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL addi_latency: got valid=%b expected 1", ex_valid_o);
      end
      @(negedge clk);
      ex_ready_i = 1'b0;
      checks++;
      if (ex_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL addi_valid_drop: got %b expected 0", ex_valid_o);
      end
      wb_done_i = 1'b1; redirect_i = 1'b0;
      @(negedge clk);
      wb_done_i = 1'b0;
      checks++;
      if (retire_cnt_o !== 32'd1 || pc_o !== 32'h8000_0004 || inst_req_o !== 1'b1) begin
         errors++;
         $display("FAIL addi_retire: got retire=%0d pc=%h req=%b expected 1/80000004/1",
                  retire_cnt_o, pc_o, inst_req_o);
      end
   endtask

   task automatic test_stall_redirect();
      int hi = 0;
      int bad = 0;
      inst_valid_i = 1'b1; inst_i = 32'h0020_81B3; ex_ready_i = 1'b0;
      sb.push_back('{inst: 32'h0020_81B3, imm: 32'h0, pc: 32'h8000_0004});
      @(negedge clk);
      inst_valid_i = 1'b0;
      checks++;
      if (type_o !== INST_R) begin
         errors++;
         $display("FAIL add_type: got %0d expected %0d", type_o, INST_R);
      end
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         if (ex_valid_o === 1'b1) hi++;
         if (ex_inst_o !== 32'h0020_81B3 || ex_imm_o !== 32'd0 || pc_o !== 32'h8000_0004 ||
             retire_cnt_o !== 32'd1) bad++;
         if (i == 5) ex_ready_i = 1'b1;
         @(negedge clk);
      end
      ex_ready_i = 1'b0;
      if (ex_valid_o === 1'b1) hi++;
      checks++;
      if (hi != 6) begin
         errors++;
         $display("FAIL stall_valid_cycles: got %0d expected 6", hi);
      end
      checks++;
      if (bad != 0 || retire_cnt_o !== 32'd1) begin
         errors++;
         $display("FAIL stall_stable: got %0d unstable cycles retire=%0d expected 0/1", bad, retire_cnt_o);
      end
      wb_done_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h8000_0100;
      @(negedge clk);
      wb_done_i = 1'b0; redirect_i = 1'b0;
      checks++;
      if (inst_addr_o !== 32'h8000_0100 || retire_cnt_o !== 32'd2 || inst_req_o !== 1'b1) begin
         errors++;
         $display("FAIL redirect: got addr=%h retire=%0d req=%b expected 80000100/2/1",
                  inst_addr_o, retire_cnt_o, inst_req_o);
      end
   endtask

   task automatic test_async_reset();
      inst_valid_i = 1'b1; inst_i = 32'h0020_81B3; ex_ready_i = 1'b0;
      sb.push_back('{inst: 32'h0020_81B3, imm: 32'h0, pc: 32'h8000_0100});
      @(negedge clk);
      inst_valid_i = 1'b0;
      @(negedge clk);
      checks++;
      if (ex_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL areset_issue: got valid=%b expected 1", ex_valid_o);
      end
      #2 rst = 1'b1;
      #1;
      sb.delete();
      checks++;
      if (ex_valid_o !== 1'b0 || inst_req_o !== 1'b0 || pc_o !== 32'h8000_0000 ||
          retire_cnt_o !== 32'd0 || ex_inst_o !== 32'd0 || ex_imm_o !== 32'd0 || halt_o !== 1'b0) begin
         errors++;
         $display("FAIL areset_values: got valid=%b req=%b pc=%h retire=%0d ir=%h imm=%h halt=%b expected reset values",
                  ex_valid_o, inst_req_o, pc_o, retire_cnt_o, ex_inst_o, ex_imm_o, halt_o);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h8000_0000) begin
         errors++;
         $display("FAIL areset_refetch: got req=%b addr=%h expected 1/80000000", inst_req_o, inst_addr_o);
      end
   endtask

   task automatic test_misaligned();
      @(negedge clk);
      inst_valid_i = 1'b1; inst_i = 32'hFFF0_0093; ex_ready_i = 1'b1;
      sb.push_back('{inst: 32'hFFF0_0093, imm: 32'hFFFF_FFFF, pc: 32'h8000_0000});
      @(negedge clk);
      inst_valid_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      ex_ready_i = 1'b0;
      wb_done_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h8000_0102;
      @(negedge clk);
      wb_done_i = 1'b0; redirect_i = 1'b0;
      checks++;
      if (halt_o !== 1'b1 || fault_o !== FAULT_MISALIGN || pc_o !== 32'h8000_0000 ||
          retire_cnt_o !== 32'd1 || inst_req_o !== 1'b0) begin
         errors++;
         $display("FAIL misaligned: got halt=%b fault=%0d pc=%h retire=%0d req=%b expected 1/3/80000000/1/0",
                  halt_o, fault_o, pc_o, retire_cnt_o, inst_req_o);
      end
   endtask

   task automatic test_ebreak();
      int bad = 0;
      do_reset();
      inst_valid_i = 1'b1; inst_i = 32'h0010_0073; ex_ready_i = 1'b1;
      @(negedge clk);
      inst_valid_i = 1'b0;
      @(negedge clk);
      checks++;
      if (halt_o !== 1'b1 || fault_o !== FAULT_NONE || retire_cnt_o !== 32'd0) begin
         errors++;
         $display("FAIL ebreak: got halt=%b fault=%0d retire=%0d expected 1/0/0", halt_o, fault_o, retire_cnt_o);
      end
      wb_done_i = 1'b1; inst_valid_i = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (inst_req_o !== 1'b0 || ex_valid_o !== 1'b0 || retire_cnt_o !== 32'd0 ||
             pc_o !== 32'h8000_0000) bad++;
      end
      wb_done_i = 1'b0; inst_valid_i = 1'b0; ex_ready_i = 1'b0;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL halt_frozen: got %0d active cycles expected 0", bad);
      end
   endtask

   task automatic test_illegal();
      do_reset();
      inst_valid_i = 1'b1; inst_i = 32'h1230_0000;
      @(negedge clk);
      inst_valid_i = 1'b0;
      checks++;
      if (type_o !== INST_ILL) begin
         errors++;
         $display("FAIL illegal_type: got %0d expected %0d", type_o, INST_ILL);
      end
      @(negedge clk);
      checks++;
      if (halt_o !== 1'b1 || fault_o !== FAULT_ILLEGAL || ex_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL illegal: got halt=%b fault=%0d valid=%b expected 1/1/0", halt_o, fault_o, ex_valid_o);
      end
   endtask

   task automatic test_timeout();
      int early = 0;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (halt_o !== 1'b0 || inst_req_o !== 1'b1) early++;
      end
      checks++;
      if (early != 0) begin
         errors++;
         $display("FAIL timeout_early: got %0d early-halt cycles expected 0", early);
      end
      @(negedge clk);
      checks++;
      if (halt_o !== 1'b1 || fault_o !== FAULT_TIMEOUT || inst_req_o !== 1'b0) begin
         errors++;
         $display("FAIL timeout: got halt=%b fault=%0d req=%b expected 1/2/0", halt_o, fault_o, inst_req_o);
      end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_stall_redirect();
      test_async_reset();
      test_misaligned();
      test_ebreak();
      test_illegal();
      test_timeout();
      repeat (2) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: got %0d pending packets expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/decode_sequencer.md
Name: decode_sequencer

Overview:
Multi-cycle control FSM that sequences one instruction at a time through fetch, decode, issue and writeback for the npc core. It owns the PC and the instruction register, and drives the rs2/funct7/type fields of the immediate-extension datapath, registering its 32-bit result. It hands the decoded packet to execute with a valid/ready handshake, then waits for writeback completion. It halts on ebreak, illegal opcode, fetch timeout or misaligned redirect.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset
TIMEOUT, 255, max cycles in FETCH without inst_valid_i before fault (1..65535)
EBREAK, 32'h0010_0073, instruction encoding that triggers halt

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
inst_req_o  out  1  fetch request; held while in FETCH
inst_addr_o  out  32  fetch address (= pc_o)
inst_valid_i  in  1  instruction data valid
inst_i  in  32  fetched instruction
rs2_o  out  5  IR[24:20] to immediate extender
funct7_o  out  7  IR[31:25] to immediate extender
type_o  out  `TYPE_BUS  decoded instruction class to immediate extender
imm32_i  in  32  extended immediate returned from extender
ex_valid_o  out  1  decoded packet valid
ex_ready_i  in  1  execute accepts packet
ex_imm_o  out  32  registered immediate
ex_inst_o  out  32  instruction register
pc_o  out  32  current PC
wb_done_i  in  1  writeback of issued instruction complete
redirect_i  in  1  qualifies redirect_pc_i, sampled with wb_done_i
redirect_pc_i  in  32  next PC on taken branch/jump
halt_o  out  1  sticky: stopped by ebreak or fault
fault_o  out  2  sticky cause: 0 none, 1 illegal, 2 fetch timeout, 3 misaligned redirect
retire_cnt_o  out  32  retired instruction count, wraps

Behaviour:
- Reset (async, immediate): state=FETCH, pc=RESET_PC, IR=0, imm=0, halt=0, fault=0, retire_cnt=0, timeout counter=0. All handshake outputs=0.
- States (3-bit): FETCH, DECODE, ISSUE, WAIT_WB, HALT.
- FETCH: inst_req_o=1, inst_addr_o=pc. On inst_valid_i: IR<=inst_i, go to DECODE, clear counter. Otherwise counter++. If counter reaches TIMEOUT-1 without valid: fault=2, halt=1, go to HALT.
- DECODE, one cycle: rs2_o/funct7_o/type_o are driven combinationally from IR. imm<=imm32_i at the end of the cycle. If IR==EBREAK, go to HALT with halt=1, fault=0, and no retire. If type is illegal, set fault=1 and halt=1. Otherwise go to ISSUE.
- Type decode (opcode IR[6:0]):
  - 0110011 -> INST_R
  - 0010011/0000011/1100111/1110011 -> INST_I
  - 0100011 -> INST_S
  - 1100011 -> INST_B
  - 0110111/0010111 -> INST_U
  - 1101111 -> INST_J
  - else -> illegal
- Fetch-to-issue latency: ex_valid_o rises 2 cycles after the inst_valid_i cycle.
- ISSUE: ex_valid_o=1. ex_inst_o, ex_imm_o and pc_o stay stable until ex_ready_i. On ex_valid_o&&ex_ready_i, go to WAIT_WB; ex_valid_o drops the next cycle.
- WAIT_WB: on wb_done_i, retire_cnt++ (wrap 2^32-1 -> 0).
  - redirect_i=1 with redirect_pc_i[1:0]!=0: fault=3, halt=1, go to HALT; pc unchanged, retire still counted.
  - redirect_i=1 and aligned: pc<=redirect_pc_i.
  - redirect_i=0: pc<=pc+4 (wraps mod 2^32).
  - Then go to FETCH.
- wb_done_i and redirect_i are ignored outside WAIT_WB. ex_ready_i is ignored outside ISSUE. inst_valid_i is ignored outside FETCH.
- HALT: absorbing; only rst leaves it. All handshake outputs=0; pc, IR and counters are frozen.
- Reset asserted mid-operation (any state) aborts the instruction with no retire and returns to the reset values above.
- type_o=INST_R when IR=0 after reset, so the extender outputs 0.

Decomposition:
- Shared defines file gets: state encodings; opcode constants OPC_*; EBREAK encoding; fault codes FAULT_*; an INST_U/INST_J/INST_ILL addition to the existing type encodings.
- One sub-module, inst_type_decode: combinational IR[6:0] -> type + illegal flag. The FSM and counters stay in the top.

Test Plan:
- addi x1,x0,-1 (32'hFFF00093) with valid on first FETCH cycle, ex_ready_i=1, wb_done_i next cycle -> type_o=INST_I, ex_imm_o=32'hFFFF_FFFF, ex_valid_o 2 cycles after valid, pc 80000000->80000004, retire_cnt=1.
- add (32'h002081B3), ex_ready_i held low 5 cycles -> ex_valid_o high 5+1 cycles with stable ex_inst_o/ex_imm_o=0; no retire before wb_done_i.
- wb_done_i with redirect_i=1, redirect_pc_i=32'h8000_0100 -> next inst_addr_o=32'h8000_0100. Same with 32'h8000_0102 -> halt_o=1, fault_o=3.
- inst_i=32'h0010_0073 -> halt_o=1, fault_o=0, retire_cnt unchanged, inst_req_o stays 0 for 20 cycles. Opcode 7'b0000000 non-zero IR -> fault_o=1.
- TIMEOUT=4, no inst_valid_i -> fault_o=2, halt_o=1 exactly 4 cycles after entering FETCH.
- rst pulsed asynchronously during ISSUE -> outputs return to reset values immediately; pc_o=RESET_PC; first fetch follows release.
